// File: rtl/ex_multu_if.sv
// ex_multu_if: handshake and data bundle between the EX stage and the
// sequential unsigned multiplier.
//   start/flush  : request a multiply / abort an in-flight one
//   a/b          : multiplicand (rs) / multiplier (rt)
//   hi_we/lo_we  : MTHI/MTLO write enables, data on wdata
//   busy/done    : RUN indicator / one-cycle completion pulse
//   hi/lo        : product halves or MTHI/MTLO values
// Modports: master drives requests (pipeline side), slave is the multiplier.
interface ex_multu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             flush;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, flush, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, flush, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/ex_multu.sv
// ex_multu: sequential unsigned shift-add multiplier for MULTU in the EX stage.
// Produces a 2*WIDTH-bit product into HI/LO after exactly WIDTH RUN cycles,
// independent of operand values. Also hosts the HI/LO registers written by
// MTHI/MTLO.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : ex_multu_if.slave (start, flush, a, b, hi_we, lo_we, wdata in;
//          busy, done, hi, lo out)
module ex_multu #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   ex_multu_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] prod;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               busy_r;
   logic               done_r;
   logic [2*WIDTH-1:0] sum;

   // Partial sum including the current step; mcand is zero-extended from a
   // WIDTH-bit operand and shifted at most WIDTH-1 times, so this never
   // overflows 2*WIDTH bits.
   always_comb begin
      sum = prod;
      if (mplier[0]) sum = prod + mcand;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // MTHI/MTLO and an accepted start may share a cycle; the
               // finished product overwrites hi/lo later.
               if (bus.hi_we) hi_r <= bus.wdata;
               if (bus.lo_we) lo_r <= bus.wdata;
               if (bus.start && !bus.flush) begin
                  mcand  <= {{WIDTH{1'b0}}, bus.a};
                  mplier <= bus.b;
                  prod   <= '0;
                  cnt    <= '0;
                  state  <= S_RUN;
                  busy_r <= 1'b1;
               end
            end
            S_RUN: begin
               if (bus.flush) begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end else begin
                  prod   <= sum;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH - 1)) begin
                     hi_r   <= sum[2*WIDTH-1:WIDTH];
                     lo_r   <= sum[WIDTH-1:0];
                     state  <= S_DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               // A write here lands after the product load, so it wins.
               if (bus.hi_we) hi_r <= bus.wdata;
               if (bus.lo_we) lo_r <= bus.wdata;
               state  <= S_IDLE;
               done_r <= 1'b0;
            end
            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
endmodule
